// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants shared by the timing generator and colorizer lookups
package vga_timing_pkg;
  localparam int CNT_W        = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing outputs bundle from the generator to the colorizer and sync pins
interface vga_timing_gen_if;
  logic                                pix_tick;
  logic [vga_timing_pkg::CNT_W-1:0]    pixel_column;
  logic [vga_timing_pkg::CNT_W-1:0]    pixel_row;
  logic                                video_on;
  logic                                horiz_sync;
  logic                                vert_sync;
  logic                                frame_start;

  modport master (
    output pix_tick, pixel_column, pixel_row, video_on, horiz_sync, vert_sync, frame_start
  );
  modport slave (
    input  pix_tick, pixel_column, pixel_row, video_on, horiz_sync, vert_sync, frame_start
  );
endinterface

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - enable-gated shift register aligning sync/blank flags with lookup latency
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, reset_n, en, rst_val};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel tick divider, h/v counters and delayed video_on/sync generation
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_POL   = 0,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DELAY = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_timing_gen_if.master   vga
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic POL     = (SYNC_POL != 0);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] h, v;
  logic             tick;
  logic             frame_start;
  logic             von_raw, hs_raw, vs_raw;
  logic [2:0]       dl_d, dl_q;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  // Tick is registered off the next divider value so it lines up with div == CLK_DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      div  <= div_nxt;
      tick <= (div_nxt == DIV_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h == H_LAST) && (v == V_LAST);
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  always_comb begin
    von_raw = (h < H_ACT) && (v < V_ACT);
    hs_raw  = (h >= HS_BEG) && (h < HS_END);
    vs_raw  = (v >= VS_BEG) && (v < VS_END);
    dl_d    = {von_raw, sync_level(hs_raw, POL), sync_level(vs_raw, POL)};
  end

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay_line (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tick),
    .rst_val ({1'b0, ~POL, ~POL}),
    .d       (dl_d),
    .q       (dl_q)
  );

  assign vga.pix_tick     = tick;
  assign vga.pixel_column = h;
  assign vga.pixel_row    = v;
  assign vga.video_on     = dl_q[2];
  assign vga.horiz_sync   = dl_q[1];
  assign vga.vert_sync    = dl_q[0];
  assign vga.frame_start  = frame_start;
endmodule
